// File: rtl/ccg_bist_pkg.sv
// Shared types, default constants and the output-folding helper for the CUT BIST sequencer.
package ccg_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } ccg_state_t;

  localparam logic [15:0] CCG_POLY_DEFAULT = 16'h1021;

  localparam int unsigned FOLD_MAX_W = 256;
  localparam int unsigned SIG_MAX_W  = 64;

  // XOR-folds a zero-extended output word into sig_w-bit chunks (bit i lands on i mod sig_w).
  function automatic logic [SIG_MAX_W-1:0] fold(input logic [FOLD_MAX_W-1:0] din,
                                                input int unsigned           sig_w);
    logic [SIG_MAX_W-1:0] acc;
    acc = '0;
    for (int unsigned i = 0; i < FOLD_MAX_W; i++) begin
      acc[6'(i % sig_w)] = acc[6'(i % sig_w)] ^ din[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ccg_bist_if.sv
// Control/status and CUT-facing bus between the BIST sequencer and the evaluation harness.
interface ccg_bist_if #(
  parameter int unsigned N_IN  = 13,
  parameter int unsigned N_OUT = 16,
  parameter int unsigned SIG_W = 16
);
  logic             start;
  logic             abort;
  logic [SIG_W-1:0] expected_sig;
  logic [N_IN-1:0]  dut_x;
  logic [N_OUT-1:0] dut_f;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [N_IN-1:0]  vec_idx;

  modport master (
    output start, abort, expected_sig, dut_f,
    input  dut_x, busy, done, pass, signature, vec_idx
  );

  modport slave (
    input  start, abort, expected_sig, dut_f,
    output dut_x, busy, done, pass, signature, vec_idx
  );
endinterface

// File: rtl/ccg_misr.sv
// Multiple-input signature register compacting one folded CUT output word per enabled cycle.
module ccg_misr
  import ccg_bist_pkg::*;
#(
  parameter int unsigned           SIG_W   = 16,
  parameter logic [SIG_W-1:0]      POLY    = SIG_W'(CCG_POLY_DEFAULT),
  parameter int unsigned           IN_W    = 16,
  parameter logic [SIG_W-1:0]      RST_SIG = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [SIG_W-1:0] seed,
  input  logic             en,
  input  logic [IN_W-1:0]  din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] din_fold_c;
  logic [SIG_W-1:0] sig_next_c;

  always_comb begin
    din_fold_c = SIG_W'(fold(FOLD_MAX_W'(din), SIG_W));
    sig_next_c = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ din_fold_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= RST_SIG;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_next_c;
    end
  end

endmodule

// File: rtl/ccg_bist_sequencer.sv
// Exhaustive BIST sequencer: walks every CUT input vector, compacts outputs into a MISR
// and compares the final signature with a golden value.
module ccg_bist_sequencer
  import ccg_bist_pkg::*;
#(
  parameter int unsigned      N_IN       = 13,
  parameter int unsigned      N_OUT      = 16,
  parameter int unsigned      SIG_W      = 16,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(CCG_POLY_DEFAULT),
  parameter logic [SIG_W-1:0] SIG_SEED   = '0,
  parameter int unsigned      SETTLE_CYC = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  ccg_bist_if.slave  bus
);

  localparam int unsigned     CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  ccg_state_t       state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             misr_load_c;
  logic             misr_en_c;
  logic [SIG_W-1:0] sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  // Abort outranks everything once a run exists; start is honoured from IDLE or DONE.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    misr_load_c = 1'b0;
    misr_en_c   = 1'b0;

    if (state_q != ST_IDLE && bus.abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d     = ST_SETTLE;
            vec_d       = '0;
            cnt_d       = CNT_LOAD;
            busy_d      = 1'b1;
            done_d      = 1'b0;
            pass_d      = 1'b0;
            misr_load_c = 1'b1;
          end else if (state_q == ST_DONE && !done_q) begin
            // First DONE cycle: signature is final, latch the verdict once.
            done_d = 1'b1;
            pass_d = (sig == bus.expected_sig);
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_d = ST_CAPTURE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          misr_en_c = 1'b1;
          if (vec_q != LAST_VEC) begin
            vec_d   = vec_q + N_IN'(1);
            cnt_d   = CNT_LOAD;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  ccg_misr #(
    .SIG_W   (SIG_W),
    .POLY    (POLY),
    .IN_W    (N_OUT),
    .RST_SIG (SIG_SEED)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (misr_load_c),
    .seed  (SIG_SEED),
    .en    (misr_en_c),
    .din   (bus.dut_f),
    .sig   (sig)
  );

  assign bus.dut_x     = vec_q;
  assign bus.vec_idx   = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.signature = sig;

endmodule
